// File: rtl/uart_lfsr_io_pkg.sv
// Shared types and constants for the UART + LFSR I/O block.
// Holds FSM state enums, LFSR constants and the baud divider helper.
package uart_lfsr_io_pkg;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT
    } rx_state_t;

    localparam int LFSR_W = 16;
    localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;
    // x^16+x^14+x^13+x^11+1 in right-shift Fibonacci form
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'h002D;

    function automatic int baud_div(input int clock_rate, input int baud_rate);
        return clock_rate / baud_rate;
    endfunction

endpackage

// File: rtl/uart_lfsr_io_baud_counter.sv
// Loadable down-counter; tick is high while the count sits at zero.
// Loading N yields the next tick N+1 cycles later.
module uart_baud_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tick
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign tick = (cnt == '0);

endmodule

// File: rtl/uart_lfsr_io.sv
// 8N1 UART transmitter and receiver with valid/ready handshakes,
// plus a free-running 16-bit LFSR random bit source.
module uart_lfsr_io
    import uart_lfsr_io_pkg::*;
#(
    parameter int CLOCK_RATE = 24000000,
    parameter int BAUD_RATE  = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_enable,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       tx_out,
    input  logic       rx_enable,
    input  logic       rx_in,
    input  logic       rx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_error,
    output logic       rx_overrun,
    output logic       random_bit
);

    localparam int DIV = baud_div(CLOCK_RATE, BAUD_RATE);
    localparam int CW  = $clog2(DIV + 1);
    localparam logic [CW-1:0] LD_BIT  = CW'(DIV - 1);
    localparam logic [CW-1:0] LD_LAST = CW'(DIV - 2);
    localparam logic [CW-1:0] LD_HALF = CW'(DIV / 2 - 1);

    tx_state_t     tx_state, tx_next;
    logic [7:0]    tx_shift;
    logic [2:0]    tx_bit;
    logic          tx_fire, tx_tick, tx_load;
    logic [CW-1:0] tx_ld_val;

    assign tx_ready = (tx_state == TX_IDLE) & tx_enable;
    assign tx_fire  = tx_valid & tx_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tx_state <= TX_IDLE;
        else        tx_state <= tx_next;
    end

    always_comb begin
        tx_next = tx_state;
        unique case (tx_state)
            TX_IDLE:  if (tx_fire) tx_next = TX_START;
            TX_START: if (tx_tick) tx_next = TX_DATA;
            TX_DATA:  if (tx_tick && tx_bit == 3'd7) tx_next = TX_STOP;
            TX_STOP:  if (tx_tick) tx_next = TX_IDLE;
            default:  tx_next = TX_IDLE;
        endcase
    end

    // Stop bit spends its last cycle in IDLE so a new frame can follow with no gap
    always_comb begin
        tx_out    = 1'b1;
        tx_load   = 1'b0;
        tx_ld_val = LD_BIT;
        unique case (tx_state)
            TX_IDLE:  tx_load = tx_fire;
            TX_START: begin
                tx_out  = 1'b0;
                tx_load = tx_tick;
            end
            TX_DATA: begin
                tx_out  = tx_shift[0];
                tx_load = tx_tick;
                if (tx_bit == 3'd7) tx_ld_val = LD_LAST;
            end
            TX_STOP:  tx_load = 1'b0;
            default:  tx_load = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_shift <= '0;
            tx_bit   <= '0;
        end else if (tx_fire) begin
            tx_shift <= tx_data;
            tx_bit   <= '0;
        end else if (tx_state == TX_DATA && tx_tick) begin
            tx_shift <= {1'b0, tx_shift[7:1]};
            tx_bit   <= tx_bit + 3'd1;
        end
    end

    uart_baud_counter #(.W(CW)) u_tx_baud (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tx_load),
        .load_val (tx_ld_val),
        .tick     (tx_tick)
    );

    rx_state_t     rx_state, rx_next;
    logic          rx_s1, rx_s2;
    logic [7:0]    rx_shift;
    logic [2:0]    rx_bit;
    logic          rx_tick, rx_load, rx_take, rx_bad;
    logic [CW-1:0] rx_ld_val;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
        end else begin
            rx_s1 <= rx_in;
            rx_s2 <= rx_s1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rx_state <= RX_IDLE;
        else        rx_state <= rx_next;
    end

    always_comb begin
        rx_next = rx_state;
        if (!rx_enable) begin
            rx_next = RX_IDLE;
        end else begin
            unique case (rx_state)
                RX_IDLE:  if (!rx_s2) rx_next = RX_START;
                RX_START: if (rx_tick) rx_next = rx_s2 ? RX_IDLE : RX_DATA;
                RX_DATA:  if (rx_tick && rx_bit == 3'd7) rx_next = RX_STOP;
                RX_STOP:  if (rx_tick) rx_next = rx_s2 ? RX_IDLE : RX_WAIT;
                RX_WAIT:  if (rx_s2) rx_next = RX_IDLE;
                default:  rx_next = RX_IDLE;
            endcase
        end
    end

    always_comb begin
        rx_load   = 1'b0;
        rx_ld_val = LD_BIT;
        rx_take   = 1'b0;
        rx_bad    = 1'b0;
        unique case (rx_state)
            RX_IDLE: begin
                rx_load   = rx_enable & ~rx_s2;
                rx_ld_val = LD_HALF;
            end
            RX_START: rx_load = rx_tick;
            RX_DATA:  rx_load = rx_tick;
            RX_STOP: begin
                rx_take = rx_enable & rx_tick & rx_s2;
                rx_bad  = rx_enable & rx_tick & ~rx_s2;
            end
            RX_WAIT:  rx_load = 1'b0;
            default:  rx_load = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_shift <= '0;
            rx_bit   <= '0;
        end else if (rx_state == RX_START && rx_tick) begin
            rx_bit <= '0;
        end else if (rx_state == RX_DATA && rx_tick) begin
            rx_shift <= {rx_s2, rx_shift[7:1]};
            rx_bit   <= rx_bit + 3'd1;
        end
    end

    // A byte landing in the same cycle the old one is consumed takes the freed slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            rx_error   <= 1'b0;
            rx_overrun <= 1'b0;
        end else begin
            rx_error <= rx_bad;
            if (rx_take && (!rx_valid || rx_ready)) begin
                rx_data    <= rx_shift;
                rx_valid   <= 1'b1;
                rx_overrun <= 1'b0;
            end else if (rx_take) begin
                rx_overrun <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid   <= 1'b0;
                rx_overrun <= 1'b0;
            end
        end
    end

    uart_baud_counter #(.W(CW)) u_rx_baud (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (rx_load),
        .load_val (rx_ld_val),
        .tick     (rx_tick)
    );

    logic [LFSR_W-1:0] lfsr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr <= LFSR_SEED;
        else        lfsr <= {^(lfsr & LFSR_TAPS), lfsr[LFSR_W-1:1]};
    end

    assign random_bit = lfsr[0];

endmodule

// File: tb/tb_uart_lfsr_io.sv
// Directed + randomized bench for uart_lfsr_io with a behavioural
// UART/LFSR reference model.
module tb_uart_lfsr_io;

    localparam int DIV = 24000000 / 115200;
    localparam logic [15:0] SEED = 16'hACE1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tx_enable, tx_valid, tx_ready, tx_out;
    logic [7:0] tx_data;
    logic       rx_enable, rx_ready, rx_valid, rx_error, rx_overrun;
    logic [7:0] rx_data;
    logic       random_bit;
    logic       rx_drv, loop;
    logic       rx_line;

    assign rx_line = loop ? tx_out : rx_drv;

    uart_lfsr_io dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tx_enable  (tx_enable),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready),
        .tx_out     (tx_out),
        .rx_enable  (rx_enable),
        .rx_in      (rx_line),
        .rx_ready   (rx_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_error   (rx_error),
        .rx_overrun (rx_overrun),
        .random_bit (random_bit)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

    logic [15:0] m;
    int          cyc;
    logic        lfsr_bad = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m   <= SEED;
            cyc <= 0;
        end else begin
            m   <= lfsr_next(m);
            cyc <= cyc + 1;
        end
    end

    always @(negedge clk) begin
        if (rst_n && random_bit !== m[0]) lfsr_bad <= 1'b1;
    end

    logic [7:0] got[$];
    int         err_cnt = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_valid && rx_ready) got.push_back(rx_data);
            if (rx_error) err_cnt <= err_cnt + 1;
        end
    end

    task automatic adv(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tx_frame(input logic [7:0] b);
        logic [9:0] fr;
        fr = {1'b1, b, 1'b0};
        tx_data  = b;
        tx_valid = 1'b1;
        chk("tx_ready_pre", 32'(tx_ready), 32'd1);
        adv(1);
        tx_valid = 1'b0;
        chk("tx_ready_drop", 32'(tx_ready), 32'd0);
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("tx_%0h_bit%0d_first", b, k), 32'(tx_out), 32'(fr[k]));
            adv(DIV / 2);
            if (k == 9) chk("tx_busy_in_stop", 32'(tx_ready), 32'd0);
            adv(DIV - 1 - DIV / 2);
            chk($sformatf("tx_%0h_bit%0d_last", b, k), 32'(tx_out), 32'(fr[k]));
            adv(1);
        end
        chk("tx_ready_back", 32'(tx_ready), 32'd1);
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        for (int k = 0; k < 10; k++) begin
            rx_drv = (k == 0) ? 1'b0 : ((k == 9) ? stop : b[k-1]);
            adv(DIV);
        end
        rx_drv = 1'b1;
    endtask

    initial begin
        logic [7:0]  rb[3];
        logic [7:0]  lb[6];
        logic [15:0] s;
        logic [15:0] w;
        int          nb, e0, prev_hs;
        logic        ok;

        rst_n = 1'b0; tx_enable = 1'b1; tx_valid = 1'b0; tx_data = '0;
        rx_enable = 1'b1; rx_ready = 1'b0; rx_drv = 1'b1; loop = 1'b0;
        adv(4);
        chk("rst_tx_out", 32'(tx_out), 32'd1);
        chk("rst_tx_ready", 32'(tx_ready), 32'd1);
        chk("rst_rx_valid", 32'(rx_valid), 32'd0);
        chk("rst_rx_error", 32'(rx_error), 32'd0);
        chk("rst_rx_overrun", 32'(rx_overrun), 32'd0);
        chk("rst_rx_data", 32'(rx_data), 32'd0);
        chk("rst_random_bit", 32'(random_bit), 32'(SEED[0]));
        tx_enable = 1'b0;
        #1;
        chk("tx_ready_disabled", 32'(tx_ready), 32'd0);
        tx_enable = 1'b1;

        // frame in flight on both sides, then reset
        rst_n = 1'b1; tx_data = 8'h00; tx_valid = 1'b1; rx_drv = 1'b0;
        adv(1);
        tx_valid = 1'b0;
        adv(300);
        chk("mid_tx_busy", 32'(tx_ready), 32'd0);
        chk("mid_tx_out", 32'(tx_out), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("abort_tx_out", 32'(tx_out), 32'd1);
        chk("abort_tx_ready", 32'(tx_ready), 32'd1);
        chk("abort_rx_valid", 32'(rx_valid), 32'd0);
        rx_drv = 1'b1;
        adv(5);
        rst_n = 1'b1;

        s = SEED;
        for (int n = 0; n < 16; n++) begin
            chk($sformatf("lfsr_bit%0d", n), 32'(random_bit), 32'(s[0]));
            s = lfsr_next(s);
            adv(1);
        end

        tx_frame(8'h55);
        tx_frame(8'($urandom_range(0, 255)));

        send_rx(8'hA3, 1'b1);
        adv(5);
        chk("rx_a3_valid", 32'(rx_valid), 32'd1);
        chk("rx_a3_data", 32'(rx_data), 32'hA3);
        chk("rx_a3_error", 32'(rx_error), 32'd0);
        adv(300);
        chk("rx_a3_hold_data", 32'(rx_data), 32'hA3);
        chk("rx_a3_hold_valid", 32'(rx_valid), 32'd1);
        rx_ready = 1'b1;
        adv(1);
        rx_ready = 1'b0;
        chk("rx_a3_consumed", 32'(rx_valid), 32'd0);

        send_rx(8'h31, 1'b1);
        send_rx(8'h20, 1'b1);
        adv(5);
        chk("ovr_data", 32'(rx_data), 32'h31);
        chk("ovr_flag", 32'(rx_overrun), 32'd1);
        chk("ovr_valid", 32'(rx_valid), 32'd1);
        rx_ready = 1'b1;
        adv(1);
        rx_ready = 1'b0;
        chk("ovr_valid_clear", 32'(rx_valid), 32'd0);
        chk("ovr_flag_clear", 32'(rx_overrun), 32'd0);

        e0 = err_cnt;
        send_rx(8'h00, 1'b0);
        adv(20);
        chk("frame_err_pulses", 32'(err_cnt - e0), 32'd1);
        chk("frame_err_no_valid", 32'(rx_valid), 32'd0);

        e0 = err_cnt;
        rx_drv = 1'b0;
        adv(50);
        rx_drv = 1'b1;
        adv(2200);
        chk("glitch_no_valid", 32'(rx_valid), 32'd0);
        chk("glitch_no_error", 32'(err_cnt - e0), 32'd0);

        rx_ready = 1'b1;
        nb = got.size();
        for (int i = 0; i < 3; i++) begin
            rb[i] = 8'($urandom_range(0, 255));
            send_rx(rb[i], 1'b1);
            adv(20);
        end
        chk("rx_rand_count", 32'(got.size()), 32'(nb + 3));
        for (int i = 0; i < 3; i++) begin
            if (got.size() > nb + i)
                chk($sformatf("rx_rand%0d", i), 32'(got[nb+i]), 32'(rb[i]));
        end

        loop = 1'b1;
        nb = got.size();
        e0 = err_cnt;
        prev_hs = 0;
        lb[0] = 8'd27; lb[1] = 8'd91; lb[2] = 8'd59; lb[3] = 8'd72;
        lb[4] = 8'($urandom_range(0, 255));
        lb[5] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 6; i++) begin
            tx_data  = lb[i];
            tx_valid = 1'b1;
            ok = 1'b0;
            for (int c = 0; c < 3000 && !ok; c++) begin
                if (tx_ready) ok = 1'b1;
                adv(1);
            end
            chk($sformatf("lb_handshake%0d", i), 32'(ok), 32'd1);
            if (i > 0) chk($sformatf("lb_gap%0d", i), 32'(cyc - prev_hs), 32'(10 * DIV));
            prev_hs = cyc;
        end
        tx_valid = 1'b0;
        for (int c = 0; c < 3000 && got.size() < nb + 6; c++) adv(1);
        chk("lb_count", 32'(got.size()), 32'(nb + 6));
        for (int i = 0; i < 6; i++) begin
            if (got.size() > nb + i)
                chk($sformatf("lb_byte%0d", i), 32'(got[nb+i]), 32'(lb[i]));
        end
        chk("lb_no_error", 32'(err_cnt - e0), 32'd0);
        chk("lb_no_overrun", 32'(rx_overrun), 32'd0);
        loop = 1'b0;
        rx_ready = 1'b0;

        while (cyc < 65535) adv(1);
        for (int j = 0; j < 16; j++) begin
            w[j] = random_bit;
            adv(1);
        end
        chk("lfsr_period", 32'(w), 32'(SEED));
        chk("lfsr_stream", 32'(lfsr_bad), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
